scroll_column_gen: RTL and testbench
====================================

# scroll_column_gen

Upstream feeder for the 5x7 LED matrix driver: produces the 7-bit `prox_col` column word shifted into the row registers on every `clk_6hz` edge, so text scrolls across the display. Holds a small writable message buffer of character codes, looks each code up in an internal 5x7 glyph ROM, and emits glyph columns followed by blank gap columns, wrapping at the end of the message. Runs entirely in the `clk_6hz` domain, the same clock the matrix rows shift on.

## Interface

- `MSG_LEN`, 8: number of character slots in the message buffer (2..16).
- `GAP_COLS`, 1: blank columns inserted after each glyph (1..3).
- `clk_6hz`  in  1: scroll clock; all state updates on rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `run`  in  1: 1 = advance through message; 0 = pause.
- `load`  in  1: write strobe for message buffer.
- `load_addr`  in  4: slot to write; values >= `MSG_LEN` ignored.
- `load_char`  in  6: character code to write.
- `prox_col`  out  7: next column; bit 6 = top row, bit 0 = bottom row.
- `char_idx`  out  4: slot currently being emitted.
- `col_idx`  out  3: glyph column 0..4, or gap column number while in GAP.
- `wrap`  out  1: one-cycle pulse on the column after the last gap column of slot `MSG_LEN-1`.

## Operation

- Character codes: 0–9 are digits '0'–'9'; 10–35 are 'A'–'Z'; 36–63 are blank, all columns 0.
- Glyph ROM: combinational, standard 5x7 font, column 0 leftmost. Classic-table bit 0 (top) maps to `prox_col[6]`.
  - 'A' = 3F,44,44,44,3F.
  - '1' = 00,21,7F,01,00.
- Message buffer: `MSG_LEN` x 6 registers, reset to code 36 (blank). Written on a rising edge when `load`=1 and `load_addr` < `MSG_LEN`.
- FSM states:
  - IDLE (reset state): `prox_col`=0. Goes to GLYPH with `char_idx`=0, `col_idx`=0 when `run`=1.
  - GLYPH: emits glyph column `col_idx` of `msg[char_idx]`. `col_idx` counts 0..4; after 4, goes to GAP with `col_idx`=0.
  - GAP: emits 0. `col_idx` counts 0..`GAP_COLS`-1; after the last gap column, goes to GLYPH with `col_idx`=0 and `char_idx` incremented.
  - Wrap: when `char_idx` = `MSG_LEN`-1, `char_idx` wraps to 0 and `wrap` pulses.
- Pause: `run`=0 in GLYPH or GAP holds state and counters, and `prox_col` outputs 0 on that edge. On resume, emission continues from the held column; that column is not lost.
- IDLE is re-entered only through `rst`.
- Write to the slot currently being emitted: the emitted column uses the code sampled at that edge (old value). The new code applies from the next edge.

## Timing

- All outputs registered. Reset values: `prox_col`=0, `char_idx`=0, `col_idx`=0, `wrap`=0, state IDLE.
- `prox_col` for a given (state, `char_idx`, `col_idx`) appears one edge after that position is reached (latency 1). The first glyph column appears on the 2nd edge after `run` rises in IDLE.
- Period = `MSG_LEN` x (5 + `GAP_COLS`) edges of running time; 48 with defaults.
- `wrap` is high for exactly one `clk_6hz` cycle per period, coincident with `prox_col` showing column 0 of slot 0.
- `rst` mid-message: all outputs return to reset values immediately, asynchronously, and the message buffer is cleared.

## Configuration

- `SCROLL_INVERT_EN` defined: `prox_col` is bitwise inverted for active-low row drivers.
  - Blank, gap, IDLE and reset value become 7'h7F.
  - 'A' column 0 becomes 7'h40.
- Not defined: active-high as described above.

## Test plan

- Reset, `run`=0 for 10 edges -> `prox_col`=0, `char_idx`=0, `wrap` never asserted.
- Load slot 0='A' (10), slot 1='1' (1), then `run`=1 -> `prox_col` sequence 3F,44,44,44,3F,00,00,21,7F,01,00,00, then 00 for the blank slots.
- Defaults, continuous run -> `wrap` pulses every 48 edges; `char_idx` 7 -> 0 on the same edge.
- Drop `run` for 3 edges during column 2 of 'A' -> three 00 outputs, then 44 (column 2) resumes, followed by 44,3F.
- Write slot 0='1' while slot 0 column 1 is being emitted -> that edge still outputs 44, next outputs 7F; `load_addr`=9 writes are ignored.
- Assert `rst` asynchronously mid-GAP -> outputs clear without a clock edge; after release plus `run`, all slots emit blank columns.

Source files
------------

// File: rtl/scroll_column_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | scroll_column_gen                                                        |
// | Scrolling-text column source for the 5x7 LED matrix: message buffer,     |
// | glyph ROM and GLYPH/GAP sequencer. SCROLL_INVERT_EN inverts prox_col_o.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module scroll_column_gen #(
    parameter int unsigned MSG_LEN  = 8,
    parameter int unsigned GAP_COLS = 1
) (
    input  logic       clk_6hz_i,
    input  logic       rst_i,
    input  logic       run_i,
    input  logic       load_i,
    input  logic [3:0] load_addr_i,
    input  logic [5:0] load_char_i,
    output logic [6:0] prox_col_o,
    output logic [3:0] char_idx_o,
    output logic [2:0] col_idx_o,
    output logic       wrap_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GLYPH = 2'd1,
        S_GAP   = 2'd2
    } state_t;

`ifdef SCROLL_INVERT_EN
    localparam logic [6:0] c_POL_MASK = 7'h7F;
`else
    localparam logic [6:0] c_POL_MASK = 7'h00;
`endif
    localparam logic [5:0] c_BLANK_CODE = 6'd36;
    localparam logic [4:0] c_MSG_LEN    = 5'(MSG_LEN);
    localparam logic [3:0] c_LAST_CHAR  = 4'(MSG_LEN - 1);
    localparam logic [2:0] c_LAST_GAP   = 3'(GAP_COLS - 1);

    state_t     state_q, state_d;
    logic [3:0] char_q, char_d;
    logic [2:0] col_q, col_d;
    logic       wrapped_q, wrapped_d;
    logic [6:0] prox_col_q, prox_col_d;
    logic [3:0] char_idx_q, char_idx_d;
    logic [2:0] col_idx_q, col_idx_d;
    logic       wrap_q, wrap_d;
    logic [5:0] msg_q [MSG_LEN];

    logic [5:0]  w_code;
    logic [39:0] w_row;
    logic [7:0]  w_byte;
    logic [6:0]  w_glyph;
    logic        w_unused_msb;

    always_ff @(posedge clk_6hz_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(MSG_LEN); i++) msg_q[i] <= c_BLANK_CODE;
        end else if (load_i && ({1'b0, load_addr_i} < c_MSG_LEN)) begin
            for (int i = 0; i < int'(MSG_LEN); i++)
                if (load_addr_i == 4'(i)) msg_q[i] <= load_char_i;
        end
    end

    always_comb begin
        w_code = c_BLANK_CODE;
        for (int i = 0; i < int'(MSG_LEN); i++)
            if (char_q == 4'(i)) w_code = msg_q[i];
    end

    // Classic font layout: one byte per column, column 0 in the top byte, bit 0 = top row.
    always_comb begin
        case (w_code)
            6'd0:  w_row = 40'h3E_51_49_45_3E;
            6'd1:  w_row = 40'h00_42_7F_40_00;
            6'd2:  w_row = 40'h42_61_51_49_46;
            6'd3:  w_row = 40'h21_41_45_4B_31;
            6'd4:  w_row = 40'h18_14_12_7F_10;
            6'd5:  w_row = 40'h27_45_45_45_39;
            6'd6:  w_row = 40'h3C_4A_49_49_30;
            6'd7:  w_row = 40'h01_71_09_05_03;
            6'd8:  w_row = 40'h36_49_49_49_36;
            6'd9:  w_row = 40'h06_49_49_29_1E;
            6'd10: w_row = 40'h7E_11_11_11_7E;
            6'd11: w_row = 40'h7F_49_49_49_36;
            6'd12: w_row = 40'h3E_41_41_41_22;
            6'd13: w_row = 40'h7F_41_41_22_1C;
            6'd14: w_row = 40'h7F_49_49_49_41;
            6'd15: w_row = 40'h7F_09_09_09_01;
            6'd16: w_row = 40'h3E_41_49_49_7A;
            6'd17: w_row = 40'h7F_08_08_08_7F;
            6'd18: w_row = 40'h00_41_7F_41_00;
            6'd19: w_row = 40'h20_40_41_3F_01;
            6'd20: w_row = 40'h7F_08_14_22_41;
            6'd21: w_row = 40'h7F_40_40_40_40;
            6'd22: w_row = 40'h7F_02_0C_02_7F;
            6'd23: w_row = 40'h7F_04_08_10_7F;
            6'd24: w_row = 40'h3E_41_41_41_3E;
            6'd25: w_row = 40'h7F_09_09_09_06;
            6'd26: w_row = 40'h3E_41_51_21_5E;
            6'd27: w_row = 40'h7F_09_19_29_46;
            6'd28: w_row = 40'h46_49_49_49_31;
            6'd29: w_row = 40'h01_01_7F_01_01;
            6'd30: w_row = 40'h3F_40_40_40_3F;
            6'd31: w_row = 40'h1F_20_40_20_1F;
            6'd32: w_row = 40'h3F_40_38_40_3F;
            6'd33: w_row = 40'h63_14_08_14_63;
            6'd34: w_row = 40'h07_08_70_08_07;
            6'd35: w_row = 40'h61_51_49_45_43;
            default: w_row = 40'h00_00_00_00_00;
        endcase
    end

    always_comb begin
        case (col_q)
            3'd0:    w_byte = w_row[39:32];
            3'd1:    w_byte = w_row[31:24];
            3'd2:    w_byte = w_row[23:16];
            3'd3:    w_byte = w_row[15:8];
            3'd4:    w_byte = w_row[7:0];
            default: w_byte = 8'h00;
        endcase
        for (int k = 0; k < 7; k++) w_glyph[6-k] = w_byte[k];
    end

    assign w_unused_msb = w_byte[7];

    always_ff @(posedge clk_6hz_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            char_q     <= 4'd0;
            col_q      <= 3'd0;
            wrapped_q  <= 1'b0;
            prox_col_q <= c_POL_MASK;
            char_idx_q <= 4'd0;
            col_idx_q  <= 3'd0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            char_q     <= char_d;
            col_q      <= col_d;
            wrapped_q  <= wrapped_d;
            prox_col_q <= prox_col_d;
            char_idx_q <= char_idx_d;
            col_idx_q  <= col_idx_d;
            wrap_q     <= wrap_d;
        end
    end

    // char_q/col_q track the position about to be emitted; the *_idx registers
    // describe the column currently on prox_col_o.
    always_comb begin
        state_d    = state_q;
        char_d     = char_q;
        col_d      = col_q;
        wrapped_d  = wrapped_q;
        prox_col_d = c_POL_MASK;
        char_idx_d = char_idx_q;
        col_idx_d  = col_idx_q;
        wrap_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run_i) begin
                    state_d = S_GLYPH;
                    char_d  = 4'd0;
                    col_d   = 3'd0;
                end
            end
            S_GLYPH: begin
                if (run_i) begin
                    prox_col_d = w_glyph ^ c_POL_MASK;
                    char_idx_d = char_q;
                    col_idx_d  = col_q;
                    if (char_q == 4'd0 && col_q == 3'd0) begin
                        wrap_d    = wrapped_q;
                        wrapped_d = 1'b0;
                    end
                    if (col_q == 3'd4) begin
                        state_d = S_GAP;
                        col_d   = 3'd0;
                    end else begin
                        col_d = col_q + 3'd1;
                    end
                end
            end
            S_GAP: begin
                if (run_i) begin
                    char_idx_d = char_q;
                    col_idx_d  = col_q;
                    if (col_q == c_LAST_GAP) begin
                        state_d = S_GLYPH;
                        col_d   = 3'd0;
                        if (char_q == c_LAST_CHAR) begin
                            char_d    = 4'd0;
                            wrapped_d = 1'b1;
                        end else begin
                            char_d = char_q + 4'd1;
                        end
                    end else begin
                        col_d = col_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign prox_col_o = prox_col_q;
    assign char_idx_o = char_idx_q;
    assign col_idx_o  = col_idx_q;
    assign wrap_o     = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_scroll_column_gen.sv
`default_nettype none
// Testbench for scroll_column_gen: directed vector table, hand-written corner
// sequences and randomized stimulus against a position-count reference model.
module tb_scroll_column_gen;

    localparam int MSG_LEN  = 8;
    localparam int GAP_COLS = 1;
    localparam int SLOT_W   = 5 + GAP_COLS;
    localparam int PERIOD   = MSG_LEN * SLOT_W;
`ifdef SCROLL_INVERT_EN
    localparam logic [6:0] MASK = 7'h7F;
`else
    localparam logic [6:0] MASK = 7'h00;
`endif

    logic       clk;
    logic       rst;
    logic       run;
    logic       load;
    logic [3:0] load_addr;
    logic [5:0] load_char;
    logic [6:0] prox_col;
    logic [3:0] char_idx;
    logic [2:0] col_idx;
    logic       wrap;

    scroll_column_gen #(.MSG_LEN(MSG_LEN), .GAP_COLS(GAP_COLS)) dut (
        .clk_6hz_i   (clk),
        .rst_i       (rst),
        .run_i       (run),
        .load_i      (load),
        .load_addr_i (load_addr),
        .load_char_i (load_char),
        .prox_col_o  (prox_col),
        .char_idx_o  (char_idx),
        .col_idx_o   (col_idx),
        .wrap_o      (wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Classic 5x7 font, 5 column bytes per character, bit 0 = top row.
    logic [7:0] font [0:179] = '{
        8'h3E,8'h51,8'h49,8'h45,8'h3E, 8'h00,8'h42,8'h7F,8'h40,8'h00,
        8'h42,8'h61,8'h51,8'h49,8'h46, 8'h21,8'h41,8'h45,8'h4B,8'h31,
        8'h18,8'h14,8'h12,8'h7F,8'h10, 8'h27,8'h45,8'h45,8'h45,8'h39,
        8'h3C,8'h4A,8'h49,8'h49,8'h30, 8'h01,8'h71,8'h09,8'h05,8'h03,
        8'h36,8'h49,8'h49,8'h49,8'h36, 8'h06,8'h49,8'h49,8'h29,8'h1E,
        8'h7E,8'h11,8'h11,8'h11,8'h7E, 8'h7F,8'h49,8'h49,8'h49,8'h36,
        8'h3E,8'h41,8'h41,8'h41,8'h22, 8'h7F,8'h41,8'h41,8'h22,8'h1C,
        8'h7F,8'h49,8'h49,8'h49,8'h41, 8'h7F,8'h09,8'h09,8'h09,8'h01,
        8'h3E,8'h41,8'h49,8'h49,8'h7A, 8'h7F,8'h08,8'h08,8'h08,8'h7F,
        8'h00,8'h41,8'h7F,8'h41,8'h00, 8'h20,8'h40,8'h41,8'h3F,8'h01,
        8'h7F,8'h08,8'h14,8'h22,8'h41, 8'h7F,8'h40,8'h40,8'h40,8'h40,
        8'h7F,8'h02,8'h0C,8'h02,8'h7F, 8'h7F,8'h04,8'h08,8'h10,8'h7F,
        8'h3E,8'h41,8'h41,8'h41,8'h3E, 8'h7F,8'h09,8'h09,8'h09,8'h06,
        8'h3E,8'h41,8'h51,8'h21,8'h5E, 8'h7F,8'h09,8'h19,8'h29,8'h46,
        8'h46,8'h49,8'h49,8'h49,8'h31, 8'h01,8'h01,8'h7F,8'h01,8'h01,
        8'h3F,8'h40,8'h40,8'h40,8'h3F, 8'h1F,8'h20,8'h40,8'h20,8'h1F,
        8'h3F,8'h40,8'h38,8'h40,8'h3F, 8'h63,8'h14,8'h08,8'h14,8'h63,
        8'h07,8'h08,8'h70,8'h08,8'h07, 8'h61,8'h51,8'h49,8'h45,8'h43
    };

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] px(input logic [6:0] v);
        return v ^ MASK;
    endfunction

    function automatic logic [6:0] font_col(input logic [5:0] code, input int c);
        logic [7:0]  b;
        logic [6:0]  r;
        if (code > 6'd35) return 7'h00;
        b = font[int'(code) * 5 + c];
        for (int k = 0; k < 7; k++) r[6-k] = b[k];
        return r;
    endfunction

    // Reference model: counts running edges since start and derives position arithmetically.
    bit         m_started;
    int         m_n;
    logic [5:0] m_msg [MSG_LEN];
    logic [6:0] m_prox;
    logic [3:0] m_char;
    logic [2:0] m_col;
    logic       m_wrap;

    task automatic model_reset();
        m_started = 1'b0;
        m_n = 0;
        for (int i = 0; i < MSG_LEN; i++) m_msg[i] = 6'd36;
        m_prox = 7'h00; m_char = 4'd0; m_col = 3'd0; m_wrap = 1'b0;
    endtask

    task automatic model_step(input bit r, input bit ld, input logic [3:0] a, input logic [5:0] ch);
        int p, slot, c;
        m_wrap = 1'b0;
        m_prox = 7'h00;
        if (!m_started) begin
            if (r) m_started = 1'b1;
        end else if (r) begin
            p    = m_n % PERIOD;
            slot = p / SLOT_W;
            c    = p % SLOT_W;
            m_char = 4'(slot);
            m_col  = (c < 5) ? 3'(c) : 3'(c - 5);
            m_prox = (c < 5) ? font_col(m_msg[slot], c) : 7'h00;
            m_wrap = (p == 0) && (m_n > 0);
            m_n++;
        end
        if (ld && int'(a) < MSG_LEN) m_msg[a] = ch;
    endtask

    task automatic drive_tick(input bit r, input bit ld, input logic [3:0] a, input logic [5:0] ch);
        run = r; load = ld; load_addr = a; load_char = ch;
        @(posedge clk);
        #1;
    endtask

    task automatic step_model(input string tag, input bit r, input bit ld,
                              input logic [3:0] a, input logic [5:0] ch);
        drive_tick(r, ld, a, ch);
        model_step(r, ld, a, ch);
        chk({tag, "_prox"}, prox_col, px(m_prox));
        chk({tag, "_char"}, char_idx, m_char);
        chk({tag, "_col"},  col_idx,  m_col);
        chk({tag, "_wrap"}, wrap,     m_wrap);
    endtask

    task automatic do_reset();
        run = 0; load = 0; load_addr = 0; load_char = 0;
        rst = 1'b1;
        #3;
        rst = 1'b0;
        #1;
    endtask

    typedef struct packed {
        logic       r;
        logic       ld;
        logic [3:0] a;
        logic [5:0] ch;
        logic [6:0] e_prox;
        logic [3:0] e_char;
        logic [2:0] e_col;
        logic       e_wrap;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic ld, input logic [3:0] a, input logic [5:0] ch,
                                input logic [6:0] ep, input logic [3:0] ec, input logic [2:0] ecol);
        vec_t v;
        v.r = r; v.ld = ld; v.a = a; v.ch = ch;
        v.e_prox = ep; v.e_char = ec; v.e_col = ecol; v.e_wrap = 1'b0;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        logic [6:0] seq_a [0:11];
        int prev_char, wcount, next_wrap;
        seq_a = '{7'h3F,7'h44,7'h44,7'h44,7'h3F,7'h00,7'h00,7'h21,7'h7F,7'h01,7'h00,7'h00};

        rst = 1'b1; run = 0; load = 0; load_addr = 0; load_char = 0;
        #12;
        chk("rst_prox", prox_col, px(7'h00));
        chk("rst_char", char_idx, 4'd0);
        chk("rst_col",  col_idx,  3'd0);
        chk("rst_wrap", wrap,     1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Idle, loads (including out-of-range addresses that alias slots 0/1), start, two glyphs.
        for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 0, 4'd0, 6'd0, 7'h00, 4'd0, 3'd0));
        tbl.push_back(mk(0, 1, 4'd0, 6'd10, 7'h00, 4'd0, 3'd0));
        tbl.push_back(mk(0, 1, 4'd1, 6'd1,  7'h00, 4'd0, 3'd0));
        tbl.push_back(mk(0, 1, 4'd9, 6'd10, 7'h00, 4'd0, 3'd0));
        tbl.push_back(mk(0, 1, 4'd8, 6'd17, 7'h00, 4'd0, 3'd0));
        tbl.push_back(mk(1, 0, 4'd0, 6'd0,  7'h00, 4'd0, 3'd0));
        for (int i = 0; i < 12; i++)
            tbl.push_back(mk(1, 0, 4'd0, 6'd0, seq_a[i], 4'(i / 6), 3'((i % 6) < 5 ? i % 6 : 0)));
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(1, 0, 4'd0, 6'd0, 7'h00, 4'd2, 3'(i < 5 ? i : 0)));

        for (int i = 0; i < tbl.size(); i++) begin
            drive_tick(tbl[i].r, tbl[i].ld, tbl[i].a, tbl[i].ch);
            chk($sformatf("tbl%0d_prox", i), prox_col, px(tbl[i].e_prox));
            chk($sformatf("tbl%0d_char", i), char_idx, tbl[i].e_char);
            chk($sformatf("tbl%0d_col", i),  col_idx,  tbl[i].e_col);
            chk($sformatf("tbl%0d_wrap", i), wrap,     tbl[i].e_wrap);
        end

        // Wrap cadence with continuous run.
        do_reset();
        drive_tick(1, 0, 0, 0);
        prev_char = char_idx; wcount = 0; next_wrap = PERIOD + 1;
        for (int e = 1; e <= 2 * PERIOD + 4; e++) begin
            drive_tick(1, 0, 0, 0);
            if (wrap === 1'b1) begin
                wcount++;
                chk("wrap_edge", e, next_wrap);
                chk("wrap_prev_char", prev_char, MSG_LEN - 1);
                chk("wrap_char", char_idx, 4'd0);
                next_wrap += PERIOD;
            end
            prev_char = char_idx;
        end
        chk("wrap_count", wcount, 2);

        // Pause during column 2 of 'A'.
        do_reset();
        drive_tick(0, 1, 4'd0, 6'd10);
        drive_tick(1, 0, 0, 0);
        drive_tick(1, 0, 0, 0); chk("pause_c0", prox_col, px(7'h3F));
        drive_tick(1, 0, 0, 0); chk("pause_c1", prox_col, px(7'h44));
        for (int i = 0; i < 3; i++) begin
            drive_tick(0, 0, 0, 0);
            chk("pause_zero", prox_col, px(7'h00));
            chk("pause_col_hold", col_idx, 3'd1);
        end
        drive_tick(1, 0, 0, 0); chk("resume_c2", prox_col, px(7'h44)); chk("resume_col", col_idx, 3'd2);
        drive_tick(1, 0, 0, 0); chk("resume_c3", prox_col, px(7'h44));
        drive_tick(1, 0, 0, 0); chk("resume_c4", prox_col, px(7'h3F));

        // Overwrite the slot being emitted.
        do_reset();
        drive_tick(0, 1, 4'd0, 6'd10);
        drive_tick(1, 0, 0, 0);
        drive_tick(1, 0, 0, 0);          chk("wr_c0", prox_col, px(7'h3F));
        drive_tick(1, 1, 4'd0, 6'd1);    chk("wr_old", prox_col, px(7'h44));
        drive_tick(1, 0, 0, 0);          chk("wr_new", prox_col, px(7'h7F));
        drive_tick(1, 0, 0, 0);          chk("wr_c3", prox_col, px(7'h01));

        // Asynchronous reset mid-message, then buffer must be blank.
        do_reset();
        model_reset();
        step_model("ar", 0, 1, 4'd0, 6'd10);
        step_model("ar", 0, 1, 4'd3, 6'd20);
        for (int i = 0; i < 1 + 3 * SLOT_W + 5; i++) step_model("ar", 1, 0, 0, 0);
        #1 rst = 1'b1;
        #1;
        chk("async_prox", prox_col, px(7'h00));
        chk("async_char", char_idx, 4'd0);
        chk("async_col",  col_idx,  3'd0);
        chk("async_wrap", wrap,     1'b0);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < PERIOD + 3; i++) step_model("post_rst", 1, 0, 0, 0);

        // Randomized run/pause/load traffic.
        do_reset();
        model_reset();
        for (int i = 0; i < 800; i++) begin
            logic       r, ld;
            logic [3:0] a;
            logic [5:0] ch;
            r  = ($urandom_range(0, 99) < 85);
            ld = ($urandom_range(0, 99) < 20);
            a  = 4'($urandom_range(0, 15));
            ch = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(36, 63)) : 6'($urandom_range(0, 35));
            step_model("rnd", r, ld, a, ch);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
